// File: rtl/n_bit_logic_unit.sv
// Registered WIDTH-bit bitwise logic unit with valid/ready handshake,
// accumulator chaining and zero/parity status flags.
module n_bit_logic_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic [2:0]       op_sel,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] logic_out,
  output logic             zero_flag,
  output logic             parity_flag
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_ANDN = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] operand_x;
  logic [WIDTH-1:0] result;
  logic             accept;

  // in_ready depends only on the output register state, never on in_valid.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign operand_x = acc_en ? acc_q : A_in;

  always_comb begin
    result = operand_x;
    case (op_e'(op_sel))
      OP_AND:  result = operand_x & B_in;
      OP_OR:   result = operand_x | B_in;
      OP_XOR:  result = operand_x ^ B_in;
      OP_NAND: result = ~(operand_x & B_in);
      OP_NOR:  result = ~(operand_x | B_in);
      OP_XNOR: result = ~(operand_x ^ B_in);
      OP_ANDN: result = operand_x & ~B_in;
      OP_PASS: result = operand_x;
      default: result = operand_x;
    endcase
  end

  // Accumulator resets to all ones so an AND chain starts from the identity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      logic_out   <= '0;
      zero_flag   <= 1'b0;
      parity_flag <= 1'b0;
      acc_q       <= '1;
    end else if (accept) begin
      out_valid   <= 1'b1;
      logic_out   <= result;
      zero_flag   <= (result == '0);
      parity_flag <= ^result;
      acc_q       <= result;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_n_bit_logic_unit.sv
// Self-checking bench for n_bit_logic_unit: directed vector table at WIDTH=4,
// handshake corner sequences, and random traffic at WIDTH=1/4/16 against a model.
module tb_n_bit_logic_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  op_sel;
  logic        acc_en;
  logic [15:0] a_bus;
  logic [15:0] b_bus;

  logic        in_ready1, in_ready4, in_ready16;
  logic        out_valid1, out_valid4, out_valid16;
  logic [0:0]  out1;
  logic [3:0]  out4;
  logic [15:0] out16;
  logic        zero1, zero4, zero16;
  logic        par1, par4, par16;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  n_bit_logic_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .A_in(a_bus[0:0]), .B_in(b_bus[0:0]), .op_sel(op_sel), .acc_en(acc_en),
    .out_valid(out_valid1), .out_ready(out_ready), .logic_out(out1),
    .zero_flag(zero1), .parity_flag(par1)
  );

  n_bit_logic_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .A_in(a_bus[3:0]), .B_in(b_bus[3:0]), .op_sel(op_sel), .acc_en(acc_en),
    .out_valid(out_valid4), .out_ready(out_ready), .logic_out(out4),
    .zero_flag(zero4), .parity_flag(par4)
  );

  n_bit_logic_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .A_in(a_bus), .B_in(b_bus), .op_sel(op_sel), .acc_en(acc_en),
    .out_valid(out_valid16), .out_ready(out_ready), .logic_out(out16),
    .zero_flag(zero16), .parity_flag(par16)
  );

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       acc;
    logic [3:0] exp_out;
    logic       exp_zero;
    logic       exp_par;
  } vec_t;

  vec_t vecs[13];

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic acc, input logic rdy);
    in_valid  = v;
    op_sel    = op;
    a_bus     = a;
    b_bus     = b;
    acc_en    = acc;
    out_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference operation computed straight from the operation table.
  function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] x,
                                         input logic [15:0] b, input int width);
    logic [15:0] r;
    logic [15:0] mask;
    mask = (width >= 16) ? 16'hFFFF : 16'((32'd1 << width) - 1);
    case (op)
      3'd0: r = x & b;
      3'd1: r = x | b;
      3'd2: r = x ^ b;
      3'd3: r = ~(x & b);
      3'd4: r = ~(x | b);
      3'd5: r = ~(x ^ b);
      3'd6: r = x & ~b;
      default: r = x;
    endcase
    return r & mask;
  endfunction

  initial begin
    int widths[3];
    logic [15:0] m_out[3];
    logic [15:0] m_acc[3];
    logic        m_zero[3];
    logic        m_par[3];
    logic        m_valid;
    logic [15:0] got_out[3];
    logic        got_zero[3];
    logic        got_par[3];
    logic        got_valid[3];
    logic        model_ready;
    int accepted;
    int consumed;

    widths = '{1, 4, 16};

    vecs[0]  = '{3'd0, 4'b1100, 4'b1010, 1'b0, 4'b1000, 1'b0, 1'b1};
    vecs[1]  = '{3'd1, 4'b1100, 4'b1010, 1'b0, 4'b1110, 1'b0, 1'b1};
    vecs[2]  = '{3'd2, 4'b1100, 4'b1010, 1'b0, 4'b0110, 1'b0, 1'b0};
    vecs[3]  = '{3'd3, 4'b1100, 4'b1010, 1'b0, 4'b0111, 1'b0, 1'b1};
    vecs[4]  = '{3'd4, 4'b1100, 4'b1010, 1'b0, 4'b0001, 1'b0, 1'b1};
    vecs[5]  = '{3'd5, 4'b1100, 4'b1010, 1'b0, 4'b1001, 1'b0, 1'b0};
    vecs[6]  = '{3'd6, 4'b1100, 4'b1010, 1'b0, 4'b0100, 1'b0, 1'b1};
    vecs[7]  = '{3'd7, 4'b1100, 4'b1010, 1'b0, 4'b1100, 1'b0, 1'b0};
    vecs[8]  = '{3'd0, 4'b1100, 4'b0011, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[9]  = '{3'd7, 4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0};
    vecs[10] = '{3'd0, 4'b0000, 4'b1101, 1'b1, 4'b1101, 1'b0, 1'b1};
    vecs[11] = '{3'd0, 4'b0000, 4'b0111, 1'b1, 4'b0101, 1'b0, 1'b0};
    vecs[12] = '{3'd1, 4'b0000, 4'b0001, 1'b1, 4'b0101, 1'b0, 1'b0};

    rst_n = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    #3;
    checkOutput("reset out_valid", {15'b0, out_valid4}, 16'h0);
    checkOutput("reset logic_out", {12'b0, out4}, 16'h0);
    checkOutput("reset zero_flag", {15'b0, zero4}, 16'h0);
    checkOutput("reset parity_flag", {15'b0, par4}, 16'h0);
    checkOutput("reset in_ready", {15'b0, in_ready4}, 16'h1);
    tick();
    rst_n = 1'b1;

    // Operation sweep and accumulate chain, one beat per cycle.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, vecs[i].op, {12'b0, vecs[i].a}, {12'b0, vecs[i].b}, vecs[i].acc, 1'b1);
      tick();
      checkOutput($sformatf("vec%0d logic_out", i), {12'b0, out4}, {12'b0, vecs[i].exp_out});
      checkOutput($sformatf("vec%0d zero_flag", i), {15'b0, zero4}, {15'b0, vecs[i].exp_zero});
      checkOutput($sformatf("vec%0d parity_flag", i), {15'b0, par4}, {15'b0, vecs[i].exp_par});
      checkOutput($sformatf("vec%0d out_valid", i), {15'b0, out_valid4}, 16'h1);
    end

    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b1);
    tick();
    checkOutput("consume out_valid", {15'b0, out_valid4}, 16'h0);
    checkOutput("consume logic_out held", {12'b0, out4}, 16'h5);

    // Backpressure: pending acc beat must wait and see the unchanged accumulator.
    applyStimulus(1'b1, 3'd7, 16'h3, 16'h0, 1'b0, 1'b1);
    tick();
    checkOutput("bp seed", {12'b0, out4}, 16'h3);
    applyStimulus(1'b1, 3'd0, 16'h0, 16'h6, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("bp%0d in_ready", i), {15'b0, in_ready4}, 16'h0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp%0d logic_out", i), {12'b0, out4}, 16'h3);
      checkOutput($sformatf("bp%0d out_valid", i), {15'b0, out_valid4}, 16'h1);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp release in_ready", {15'b0, in_ready4}, 16'h1);
    @(posedge clk);
    #1;
    checkOutput("bp beat2", {12'b0, out4}, 16'h2);
    applyStimulus(1'b1, 3'd1, 16'h0, 16'h8, 1'b1, 1'b1);
    tick();
    checkOutput("bp beat3", {12'b0, out4}, 16'hA);
    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b1);
    tick();
    checkOutput("bp drain out_valid", {15'b0, out_valid4}, 16'h0);

    // Back-to-back consume and accept: out_valid must never drop.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'd2, 16'(i), 16'hF, 1'b0, 1'b1);
      tick();
      checkOutput($sformatf("stream%0d out_valid", i), {15'b0, out_valid4}, 16'h1);
      checkOutput($sformatf("stream%0d logic_out", i), {12'b0, out4}, {12'b0, ~4'(i)});
    end

    // Asynchronous reset while a result is held under backpressure.
    applyStimulus(1'b1, 3'd7, 16'h6, 16'h0, 1'b0, 1'b0);
    tick();
    checkOutput("mid reset held valid", {15'b0, out_valid4}, 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset out_valid", {15'b0, out_valid4}, 16'h0);
    checkOutput("mid reset logic_out", {12'b0, out4}, 16'h0);
    checkOutput("mid reset in_ready", {15'b0, in_ready4}, 16'h1);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'd7, 16'h0, 16'h0, 1'b1, 1'b1);
    tick();
    checkOutput("acc reset w4", {12'b0, out4}, 16'hF);
    checkOutput("acc reset w16", out16, 16'hFFFF);
    checkOutput("acc reset w1", {15'b0, out1}, 16'h1);

    // Random traffic at all three widths against the reference model.
    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_valid = 1'b0;
    for (int w = 0; w < 3; w++) begin
      m_out[w]  = 16'h0;
      m_acc[w]  = ref_op(3'd7, 16'hFFFF, 16'h0, widths[w]);
      m_zero[w] = 1'b0;
      m_par[w]  = 1'b0;
    end
    accepted = 0;
    consumed = 0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom), 16'($urandom), 16'($urandom),
                    1'($urandom), $urandom_range(0, 2) != 0);
      #1;
      model_ready = !m_valid || out_ready;
      checkOutput("rand in_ready w4", {15'b0, in_ready4}, {15'b0, model_ready});
      if (in_valid && in_ready16) accepted++;
      if (out_valid16 && out_ready) consumed++;
      if (in_valid && model_ready) begin
        for (int w = 0; w < 3; w++) begin
          m_out[w]  = ref_op(op_sel, acc_en ? m_acc[w] : a_bus, b_bus, widths[w]);
          m_acc[w]  = m_out[w];
          m_zero[w] = (m_out[w] == 16'h0);
          m_par[w]  = ^m_out[w];
        end
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      got_out   = '{{15'b0, out1}, {12'b0, out4}, out16};
      got_zero  = '{zero1, zero4, zero16};
      got_par   = '{par1, par4, par16};
      got_valid = '{out_valid1, out_valid4, out_valid16};
      for (int w = 0; w < 3; w++) begin
        checkOutput($sformatf("rand c%0d w%0d out_valid", cyc, widths[w]), {15'b0, got_valid[w]}, {15'b0, m_valid});
        checkOutput($sformatf("rand c%0d w%0d logic_out", cyc, widths[w]), got_out[w], m_out[w]);
        checkOutput($sformatf("rand c%0d w%0d zero_flag", cyc, widths[w]), {15'b0, got_zero[w]}, {15'b0, m_zero[w]});
        checkOutput($sformatf("rand c%0d w%0d parity_flag", cyc, widths[w]), {15'b0, got_par[w]}, {15'b0, m_par[w]});
      end
    end

    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b1);
    #1;
    if (out_valid16 && out_ready) consumed++;
    @(posedge clk);
    #1;
    checkOutput("drain out_valid w16", {15'b0, out_valid16}, 16'h0);
    checkOutput("accepted vs consumed", 16'(accepted), 16'(consumed));
    $display("[TB] random phase: %0d beats accepted", accepted);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
